// File: rtl/mem_1r1w_ctrl_pkg.sv
// ============================================================================
// Module      : mem_1r1w_ctrl_pkg
// Description : Shared geometry constants and controller state encoding for
//               the mem_1r1w (48 x 64, 1R1W) SRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_1r1w_ctrl_pkg;

  localparam int DEPTH  = 48;
  localparam int WIDTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);

  // S_INIT zero-fills the array; S_RUN serves client traffic.
  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_1r1w_ctrl_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. A lone requester always wins;
//               on contention the pointer decides, and after every grant the
//               pointer moves to the other client.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // 0: client 0 has priority on contention, 1: client 1 has priority.
  logic ptr_q;
  logic ptr_d;

  // Grant selection and pointer advance.
  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    if (grant[0]) ptr_d = 1'b1;
    if (grant[1]) ptr_d = 1'b0;
  end

  // Pointer register; reset favours client 0.
  always_ff @(posedge clock) begin
    if (!resetn) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/mem_1r1w_ctrl.sv
// ============================================================================
// Module      : mem_1r1w_ctrl
// Description : Two-client controller for the mem_1r1w SRAM. Zero-fills the
//               array after reset, then round-robins reads and writes on
//               independent ports, returns read data one cycle after accept,
//               bypasses same-cycle write data to a colliding read and
//               rejects addresses >= DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_1r1w_ctrl
  import mem_1r1w_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  output logic              init_done,
  input  logic [1:0]        rd_valid,
  output logic [1:0]        rd_ready,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [1:0]        rd_resp_valid,
  output logic [WIDTH-1:0]  rd_resp_data,
  output logic              rd_resp_err,
  input  logic [1:0]        wr_valid,
  output logic [1:0]        wr_ready,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [WIDTH-1:0]  wr_data0,
  input  logic [WIDTH-1:0]  wr_data1,
  output logic              wr_err,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [WIDTH-1:0]  R0_data,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [WIDTH-1:0]  W0_data
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fill_q, fill_d;
  logic [1:0]          owner_q, owner_d;
  logic                err_q, err_d;
  logic                byp_q, byp_d;
  logic [WIDTH-1:0]    byp_data_q, byp_data_d;

  logic                run;
  logic [1:0]          rd_req, wr_req;
  logic [1:0]          rd_gnt, wr_gnt;
  logic [ADDR_W-1:0]   rd_sel, wr_sel;
  logic [WIDTH-1:0]    wr_sel_data;
  logic                rd_ok, wr_ok, rd_acc, wr_acc;

  // Requests reach the arbiters only while serving traffic out of reset.
  always_comb begin
    run    = resetn && (state_q == S_RUN);
    rd_req = rd_valid & {2{run}};
    wr_req = wr_valid & {2{run}};
  end

  rr_arb2 u_rd_arb (
    .clock  (clock),
    .resetn (resetn),
    .valid  (rd_req),
    .grant  (rd_gnt)
  );

  rr_arb2 u_wr_arb (
    .clock  (clock),
    .resetn (resetn),
    .valid  (wr_req),
    .grant  (wr_gnt)
  );

  // Winner selection, memory port drive, next state and response capture.
  always_comb begin
    rd_sel      = rd_gnt[1] ? rd_addr1 : rd_addr0;
    wr_sel      = wr_gnt[1] ? wr_addr1 : wr_addr0;
    wr_sel_data = wr_gnt[1] ? wr_data1 : wr_data0;
    // Full-width compare so 48..63 never alias onto real entries.
    rd_ok       = rd_sel < ADDR_W'(DEPTH);
    wr_ok       = wr_sel < ADDR_W'(DEPTH);
    rd_acc      = |rd_gnt;
    wr_acc      = |wr_gnt;

    init_done   = run;
    rd_ready    = rd_gnt;
    wr_ready    = wr_gnt;
    R0_en       = rd_acc && rd_ok;
    R0_addr     = rd_sel;
    wr_err      = wr_acc && !wr_ok;
    W0_en       = wr_acc && wr_ok;
    W0_addr     = wr_sel;
    W0_data     = wr_sel_data;

    state_d     = state_q;
    fill_d      = fill_q;

    if (state_q == S_INIT) begin
      W0_en   = resetn;
      W0_addr = fill_q;
      W0_data = '0;
      fill_d  = fill_q + ADDR_W'(1);
      if (fill_q == ADDR_W'(DEPTH - 1)) begin
        state_d = S_RUN;
        fill_d  = '0;
      end
    end

    owner_d    = rd_gnt;
    err_d      = rd_acc && !rd_ok;
    // Array read returns pre-write contents, so a same-address write must
    // be carried to the response through this register.
    byp_d      = rd_acc && rd_ok && wr_acc && wr_ok && (rd_sel == wr_sel);
    byp_data_d = wr_sel_data;
  end

  // FSM, fill counter and response-path registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_INIT;
      fill_q     <= '0;
      owner_q    <= 2'b00;
      err_q      <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  // Response strobe is suppressed while reset is held so a pending
  // response never escapes once reset is asserted.
  always_comb begin
    rd_resp_valid = owner_q & {2{resetn}};
    rd_resp_err   = err_q && resetn;
    if (err_q)      rd_resp_data = '0;
    else if (byp_q) rd_resp_data = byp_data_q;
    else            rd_resp_data = R0_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_1r1w_ctrl.sv
// ============================================================================
// Module      : tb_mem_1r1w_ctrl
// Description : Directed self-checking bench for mem_1r1w_ctrl with a
//               behavioural 1R1W SRAM (registered read, read-before-write).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_1r1w_ctrl;
  import mem_1r1w_ctrl_pkg::*;

  logic              clock = 1'b0;
  logic              resetn;
  logic              init_done;
  logic [1:0]        rd_valid, rd_ready, rd_resp_valid;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1;
  logic [WIDTH-1:0]  rd_resp_data;
  logic              rd_resp_err;
  logic [1:0]        wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr0, wr_addr1;
  logic [WIDTH-1:0]  wr_data0, wr_data1;
  logic              wr_err;
  logic [ADDR_W-1:0] R0_addr, W0_addr;
  logic              R0_en, W0_en;
  logic [WIDTH-1:0]  R0_data, W0_data;

  int n_cmp = 0;
  int n_bad = 0;
  int oor_wr = 0;

  always #5 clock = ~clock;

  mem_1r1w_ctrl dut (
    .clock(clock), .resetn(resetn), .init_done(init_done),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .rd_resp_err(rd_resp_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_err(wr_err),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data)
  );

  // SRAM model: seeded with non-zero junk so the zero-fill is observable.
  logic [WIDTH-1:0] mem [0:63];
  logic             seeded = 1'b0;
  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
      seeded <= 1'b1;
    end else begin
      if (R0_en) R0_data <= mem[R0_addr];
      if (W0_en) begin
        mem[W0_addr] <= W0_data;
        if (W0_addr >= 6'd48) oor_wr <= oor_wr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] rv, input logic [5:0] ra0, input logic [5:0] ra1,
                        input logic [1:0] wv, input logic [5:0] wa0, input logic [5:0] wa1,
                        input logic [63:0] wd0, input logic [63:0] wd1);
    rd_valid = rv; rd_addr0 = ra0; rd_addr1 = ra1;
    wr_valid = wv; wr_addr0 = wa0; wr_addr1 = wa1;
    wr_data0 = wd0; wr_data1 = wd1;
  endtask

  task automatic idle();
    set_in(2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0);
  endtask

  // Inputs change at posedge+1, outputs are sampled at the falling edge.
  task automatic mid();
    #4;
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    resetn = 1'b0;
    idle();
    nxt();
    nxt();
    mid();
    chk("rst_init_done", init_done, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_resp_valid", rd_resp_valid, 0);
    chk("rst_resp_err", rd_resp_err, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_R0_en", R0_en, 0);
    chk("rst_W0_en", W0_en, 0);
    nxt();

    // Zero-fill: cycle k writes address k; requests are held off.
    resetn = 1'b1;
    rd_valid = 2'b11;
    for (int k = 0; k < 48; k++) begin
      mid();
      chk("fill_en", W0_en, 1);
      chk("fill_addr", W0_addr, 64'(k));
      chk("fill_data", W0_data, 0);
      chk("fill_init_done", init_done, 0);
      chk("fill_rd_ready", rd_ready, 0);
      nxt();
    end
    idle();
    mid();
    chk("run_init_done", init_done, 1);
    chk("run_no_write", W0_en, 0);
    nxt();

    // Client 1 reads the last entry, expecting the fill value.
    set_in(2'b10, 6'd0, 6'd47, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0);
    mid();
    chk("rd47_ready", rd_ready, 2'b10);
    chk("rd47_R0_en", R0_en, 1);
    chk("rd47_R0_addr", R0_addr, 47);
    nxt();
    idle();
    mid();
    chk("rd47_resp_valid", rd_resp_valid, 2'b10);
    chk("rd47_data", rd_resp_data, 0);
    chk("rd47_err", rd_resp_err, 0);
    nxt();

    // Client 1 writes 0xDEADBEEF to address 5.
    set_in(2'b00, 6'd0, 6'd0, 2'b10, 6'd0, 6'd5, 64'd0, 64'hDEAD_BEEF);
    mid();
    chk("wr5_ready", wr_ready, 2'b10);
    chk("wr5_W0_en", W0_en, 1);
    chk("wr5_W0_addr", W0_addr, 5);
    chk("wr5_W0_data", W0_data, 64'hDEAD_BEEF);
    chk("wr5_wr_err", wr_err, 0);
    nxt();

    // Both clients read every cycle: grants alternate, responses back-to-back.
    set_in(2'b11, 6'd5, 6'd47, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0);
    for (int j = 0; j < 5; j++) begin
      if (j == 4) idle();
      mid();
      if (j < 4) chk("rr_rd_grant", rd_ready, exp_g[j]);
      if (j > 0) begin
        chk("rr_rd_resp_valid", rd_resp_valid, exp_g[j-1]);
        chk("rr_rd_data", rd_resp_data, (exp_g[j-1] == 2'b01) ? 64'hDEAD_BEEF : 64'd0);
      end
      nxt();
    end

    // Both clients write address 10: client 0 first, then client 1.
    set_in(2'b00, 6'd0, 6'd0, 2'b11, 6'd10, 6'd10, 64'h1111, 64'h2222);
    mid();
    chk("rr_wr_grant0", wr_ready, 2'b01);
    chk("rr_wr_data0", W0_data, 64'h1111);
    chk("rr_wr_addr0", W0_addr, 10);
    nxt();
    mid();
    chk("rr_wr_grant1", wr_ready, 2'b10);
    chk("rr_wr_data1", W0_data, 64'h2222);
    nxt();
    set_in(2'b01, 6'd10, 6'd0, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0);
    mid();
    chk("rd10_ready", rd_ready, 2'b01);
    nxt();
    idle();
    mid();
    chk("rd10_resp_valid", rd_resp_valid, 2'b01);
    chk("rd10_data", rd_resp_data, 64'h2222);
    nxt();

    // Collision at address 20: old value 0x5555, new write 0xABCD.
    set_in(2'b00, 6'd0, 6'd0, 2'b01, 6'd20, 6'd0, 64'h5555, 64'd0);
    mid();
    chk("wr20_ready", wr_ready, 2'b01);
    nxt();
    set_in(2'b01, 6'd20, 6'd0, 2'b01, 6'd20, 6'd0, 64'hABCD, 64'd0);
    mid();
    chk("col_rd_ready", rd_ready, 2'b01);
    chk("col_wr_ready", wr_ready, 2'b01);
    nxt();
    set_in(2'b01, 6'd20, 6'd0, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0);
    mid();
    chk("col_resp_valid", rd_resp_valid, 2'b01);
    chk("col_data", rd_resp_data, 64'hABCD);
    nxt();
    idle();
    mid();
    chk("col_array_data", rd_resp_data, 64'hABCD);
    nxt();

    // Out-of-range read.
    set_in(2'b10, 6'd0, 6'd50, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0);
    mid();
    chk("oor_rd_ready", rd_ready, 2'b10);
    chk("oor_rd_R0_en", R0_en, 0);
    nxt();
    idle();
    mid();
    chk("oor_rd_resp_valid", rd_resp_valid, 2'b10);
    chk("oor_rd_err", rd_resp_err, 1);
    chk("oor_rd_data", rd_resp_data, 0);
    nxt();

    // Out-of-range write, then read the entry 63 would alias to (15).
    set_in(2'b00, 6'd0, 6'd0, 2'b10, 6'd0, 6'd63, 64'd0, 64'hFFFF);
    mid();
    chk("oor_wr_ready", wr_ready, 2'b10);
    chk("oor_wr_W0_en", W0_en, 0);
    chk("oor_wr_err", wr_err, 1);
    nxt();
    set_in(2'b01, 6'd15, 6'd0, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0);
    mid();
    chk("oor_wr_err_pulse", wr_err, 0);
    nxt();
    idle();
    mid();
    chk("alias15_data", rd_resp_data, 0);
    chk("alias15_err", rd_resp_err, 0);
    nxt();

    // Reset in the cycle after a read accept.
    set_in(2'b01, 6'd5, 6'd0, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0);
    mid();
    chk("pre_rst_ready", rd_ready, 2'b01);
    nxt();
    resetn = 1'b0;
    idle();
    mid();
    chk("mid_rst_resp_valid", rd_resp_valid, 0);
    chk("mid_rst_init_done", init_done, 0);
    nxt();
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      mid();
      chk("refill_addr", W0_addr, 64'(k));
      chk("refill_init_done", init_done, 0);
      nxt();
    end
    // Reset during fill restarts from address 0.
    resetn = 1'b0;
    mid();
    chk("fill_rst_W0_en", W0_en, 0);
    nxt();
    resetn = 1'b1;
    for (int k = 0; k < 48; k++) begin
      mid();
      chk("refill2_en", W0_en, 1);
      chk("refill2_addr", W0_addr, 64'(k));
      chk("refill2_init_done", init_done, 0);
      nxt();
    end
    set_in(2'b11, 6'd5, 6'd47, 2'b00, 6'd0, 6'd0, 64'd0, 64'd0);
    mid();
    chk("refill_done", init_done, 1);
    chk("ptr_reset_grant", rd_ready, 2'b01);
    nxt();
    idle();
    mid();
    chk("refill_rd5_valid", rd_resp_valid, 2'b01);
    chk("refill_rd5_data", rd_resp_data, 0);
    nxt();

    chk("oor_array_writes", 64'(oor_wr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
